fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 67 ++++++
 tb/tb_fifo_wr_arbiter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: 4-way round-robin write arbiter for a shared FIFO.
// Define FIFO_ARB_LOCK_EN to compile in burst locking (ARB/LOCK FSM).
module fifo_wr_arbiter #(
  parameter int B = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [3:0]     req,
  input  logic [3:0]     lock,
  input  logic [4*B-1:0] din,
  input  logic           fifo_full,
  output logic [3:0]     gnt,
  output logic           fifo_wr,
  output logic [B-1:0]   fifo_w_data,
  output logic           locked
);
  typedef enum logic {ARB, LOCK} state_t;
  state_t     r_state, w_next;
  logic [1:0] r_last, r_owner, w_owner_next, w_idx;
  logic [3:0] w_elig;
  logic       w_hit;
  always_comb begin
    w_elig = (r_state == LOCK) ? (req & (4'b1 << r_owner)) : req;
    w_hit  = 1'b0;
    w_idx  = r_last;
    for (int k = 1; k <= 4; k++)
      if (!w_hit && w_elig[r_last + 2'(k)]) begin
        w_hit = 1'b1;
        w_idx = r_last + 2'(k);
      end
  end
  // Outputs are forced low while reset is held, independent of the clock.
  assign fifo_wr     = w_hit & ~fifo_full & ~reset;
  assign gnt         = fifo_wr ? 4'b1 << w_idx : 4'b0;
  assign fifo_w_data = fifo_wr ? din[w_idx*B +: B] : '0;
  assign locked      = (r_state == LOCK) & ~reset;
`ifdef FIFO_ARB_LOCK_EN
  always_comb begin
    w_next       = r_state;
    w_owner_next = r_owner;
    if (r_state == ARB) begin
      if (fifo_wr && lock[w_idx]) begin
        w_next       = LOCK;
        w_owner_next = w_idx;
      end
    end else if (!req[r_owner] || (fifo_wr && !lock[r_owner]))
      w_next = ARB;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  always_comb begin
    w_next       = ARB;
    w_owner_next = 2'd0;
  end
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_last  <= 2'd3;
      r_state <= ARB;
      r_owner <= 2'd0;
    end else begin
      if (fifo_wr) r_last <= w_idx;
      r_state <= w_next;
      r_owner <= w_owner_next;
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench with a queue-fed monitor and a
// rule-level reference model (honours FIFO_ARB_LOCK_EN like the design).
module tb_fifo_wr_arbiter;
  logic        clk = 0, reset = 1, fifo_full = 0;
  logic [3:0]  req = 0, lock = 0, gnt;
  logic [31:0] din = 0;
  logic        fifo_wr, locked;
  logic [7:0]  fifo_w_data;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic       w;
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t q[$];

  int m_last = 3, m_own = 0;
  bit m_lk = 0;

  fifo_wr_arbiter #(.B(8)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .din(din),
    .fifo_full(fifo_full), .gnt(gnt), .fifo_wr(fifo_wr),
    .fifo_w_data(fifo_w_data), .locked(locked)
  );

  always #5 clk = ~clk;

  // Round-robin from the last winner; in a burst only the owner may win.
  function automatic int pick(logic [3:0] r, logic f);
    if (f) return -1;
    for (int k = 1; k <= 4; k++) begin
      int p = (m_last + k) % 4;
      if (r[p] && (!m_lk || p == m_own)) return p;
    end
    return -1;
  endfunction

  task automatic step(input logic rs, input logic [3:0] r, input logic [3:0] lk,
                      input logic [31:0] d, input logic f, output int g);
    exp_t e;
    @(negedge clk);
    reset = rs; req = r; lock = lk; din = d; fifo_full = f;
    g = -1;
    if (rs) begin
      e = '0;
      m_last = 3; m_lk = 0; m_own = 0;
    end else begin
      g   = pick(r, f);
      e.g = (g < 0) ? 4'b0 : 4'(1 << g);
      e.w = (g >= 0);
      e.d = (g < 0) ? 8'h00 : d[g*8 +: 8];
      e.l = m_lk;
      if (g >= 0) m_last = g;
`ifdef FIFO_ARB_LOCK_EN
      if (!m_lk) begin
        if (g >= 0 && lk[g]) begin m_lk = 1; m_own = g; end
      end else if (!r[m_own] || (g == m_own && !lk[m_own])) m_lk = 0;
`endif
    end
    q.push_back(e);
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, x);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.g));
      chk("fifo_wr", 32'(fifo_wr), 32'(e.w));
      chk("fifo_w_data", 32'(fifo_w_data), 32'(e.d));
      chk("locked", 32'(locked), 32'(e.l));
    end
  end

  initial begin
    int g;
    logic [3:0]  pend;
    logic [31:0] pd;
    step(1, 4'b0000, 4'b0000, 32'h0, 0, g);
    step(1, 4'b1111, 4'b1111, 32'hFFFFFFFF, 0, g);
    // all four requesting: 0,1,2,3 repeated
    for (int i = 0; i < 8; i++) step(0, 4'b1111, 4'b0000, 32'h44332211 + 32'(i), 0, g);
    // full stalls a waiting request without loss
    step(1, 4'b0000, 4'b0000, 32'h0, 0, g);
    for (int i = 0; i < 3; i++) step(0, 4'b0100, 4'b0000, 32'h00A50000, 1, g);
    step(0, 4'b0100, 4'b0000, 32'h00A50000, 0, g);
    // wrap-around priority from last=1
    step(0, 4'b0010, 4'b0000, 32'h00003C00, 0, g);
    step(0, 4'b0011, 4'b0000, 32'h00005A69, 0, g);
    step(0, 4'b0010, 4'b0000, 32'h00005A69, 0, g);
    // port 0 burst of four words
    step(1, 4'b0000, 4'b0000, 32'h0, 0, g);
    for (int i = 0; i < 3; i++) step(0, 4'b0011, 4'b0001, 32'h0000B000 + 32'(i), 0, g);
    step(0, 4'b0011, 4'b0000, 32'h0000B0C3, 0, g);
    step(0, 4'b0010, 4'b0000, 32'h0000B0C3, 0, g);
    // port 1 burst abandoned by dropping req
    step(1, 4'b0000, 4'b0000, 32'h0, 0, g);
    step(0, 4'b0010, 4'b0010, 32'h00771100, 0, g);
    step(0, 4'b0110, 4'b0010, 32'h00771200, 0, g);
    step(0, 4'b0100, 4'b0000, 32'h00770000, 0, g);
    step(0, 4'b0100, 4'b0000, 32'h00770000, 0, g);
    // reset mid-burst
    step(1, 4'b0000, 4'b0000, 32'h0, 0, g);
    step(0, 4'b1111, 4'b0001, 32'hDDCCBBAA, 0, g);
    step(0, 4'b1111, 4'b0001, 32'hDDCCBBAA, 0, g);
    step(1, 4'b1111, 4'b0001, 32'hDDCCBBAA, 0, g);
    step(0, 4'b1111, 4'b0000, 32'hDDCCBBAA, 0, g);
    // randomized traffic: requests held until granted
    pend = 0; pd = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1;
          pd[i*8 +: 8] = 8'($urandom);
        end
      if ($urandom_range(99) == 0) begin
        step(1, pend, 4'($urandom), pd, 1'($urandom), g);
        pend = 0;
      end else begin
        step(0, pend, 4'($urandom), pd, $urandom_range(3) == 0, g);
        if (g >= 0) pend[g] = 0;
      end
    end
    step(0, 4'b0000, 4'b0000, 32'h0, 0, g);
    repeat (3) @(negedge clk);
    #4;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
